sfp_los_debounce: RTL and testbench

Per-channel debounce and event tracker for the 24 qualified SFP loss-of-signal lines that the chip register block produces after its force-enable/force-value override. It samples the qualified LOS vector in the 100 MHz register clock domain and filters glitches with a programmable stability window. It reports a clean LOS level, per-channel sticky change flags, saturating loss-event counters and a maskable interrupt to the register map and link-engine control logic.

---
 rtl/sfp_los_debounce_if.sv | 47 ++++
 rtl/sfp_los_debounce.sv | 174 +++++++++++++++++
 tb/tb_sfp_los_debounce.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfp_los_debounce_if.sv
// Register-map side bundle of the SFP LOS debounce block.
// The debounce block connects through the slave modport; the block that drives its inputs uses master.
interface sfp_los_debounce_if #(
  parameter int pNUMCH = 24,
  parameter int pDBW   = 20,
  parameter int pCNTW  = 16
) ();

  logic [pNUMCH-1:0] iSFP_LOS_QUAL;
  logic [pDBW-1:0]   iDEBOUNCE_CLKS;
  logic [pNUMCH-1:0] iINT_MASK;
  logic [pNUMCH-1:0] iSTICKY_CLR;
  logic              iCNT_CLR;
  logic [4:0]        iCNT_SEL;

  logic [pNUMCH-1:0] oLOS_DB;
  logic [pNUMCH-1:0] oLOS_CHG_STICKY;
  logic [pCNTW-1:0]  oCNT_RD;
  logic              oINT;

  modport master (
    output iSFP_LOS_QUAL,
    output iDEBOUNCE_CLKS,
    output iINT_MASK,
    output iSTICKY_CLR,
    output iCNT_CLR,
    output iCNT_SEL,
    input  oLOS_DB,
    input  oLOS_CHG_STICKY,
    input  oCNT_RD,
    input  oINT
  );

  modport slave (
    input  iSFP_LOS_QUAL,
    input  iDEBOUNCE_CLKS,
    input  iINT_MASK,
    input  iSTICKY_CLR,
    input  iCNT_CLR,
    input  iCNT_SEL,
    output oLOS_DB,
    output oLOS_CHG_STICKY,
    output oCNT_RD,
    output oINT
  );

endinterface

// File: rtl/sfp_los_debounce.sv
// Per-channel LOS synchronizer, glitch filter, sticky change flags and saturating loss-event counters.
// Channels power up reporting loss; a channel's level flips only after W consecutive differing samples.
module sfp_los_debounce #(
  parameter int pNUMCH = 24,
  parameter int pDBW   = 20,
  parameter int pCNTW  = 16
) (
  input  logic               iCLK_100M,
  input  logic               iRST_100M_n,
  sfp_los_debounce_if.slave  bus
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  localparam logic [pNUMCH-1:0] CH_ONES  = {pNUMCH{1'b1}};
  localparam logic [pNUMCH-1:0] CH_ZERO  = {pNUMCH{1'b0}};
  localparam logic [pDBW-1:0]   DB_ZERO  = {pDBW{1'b0}};
  localparam logic [pDBW-1:0]   DB_ONE   = {{(pDBW-1){1'b0}}, 1'b1};
  localparam logic [pDBW-1:0]   DB_MAX   = {pDBW{1'b1}};
  localparam logic [pCNTW-1:0]  CNT_ZERO = {pCNTW{1'b0}};
  localparam logic [pCNTW-1:0]  CNT_ONE  = {{(pCNTW-1){1'b0}}, 1'b1};
  localparam logic [pCNTW-1:0]  CNT_MAX  = {pCNTW{1'b1}};

  logic [pNUMCH-1:0] sync1_q;
  logic [pNUMCH-1:0] sync2_q;

  db_state_e         db_state_s [pNUMCH];
  logic [pDBW:0]     win_s;
  logic [pNUMCH-1:0] toggle_s;
  logic [pNUMCH-1:0] rise_s;

  logic [pNUMCH-1:0] los_db_q;
  logic [pNUMCH-1:0] los_db_d;
  logic [pDBW-1:0]   db_cnt_q [pNUMCH];
  logic [pDBW-1:0]   db_cnt_d [pNUMCH];

  logic [pNUMCH-1:0] sticky_q;
  logic [pNUMCH-1:0] sticky_d;
  logic [pCNTW-1:0]  cnt_q [pNUMCH];
  logic [pCNTW-1:0]  cnt_d [pNUMCH];
  logic [pCNTW-1:0]  cnt_rd_q;
  logic [pCNTW-1:0]  cnt_rd_d;
  logic              int_q;
  logic              int_d;

  // Two-flop synchronizer; idles at "loss" so nothing flips right after reset.
  always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
    if (!iRST_100M_n) begin
      sync1_q <= CH_ONES;
      sync2_q <= CH_ONES;
    end else begin
      sync1_q <= bus.iSFP_LOS_QUAL;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state register: filtered level plus per-channel window counter.
  always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
    if (!iRST_100M_n) begin
      los_db_q <= CH_ONES;
      for (int ch = 0; ch < pNUMCH; ch++) begin
        db_cnt_q[ch] <= DB_ZERO;
      end
    end else begin
      los_db_q <= los_db_d;
      for (int ch = 0; ch < pNUMCH; ch++) begin
        db_cnt_q[ch] <= db_cnt_d[ch];
      end
    end
  end

  // State decode and effective window; a zero window still needs one differing sample.
  always_comb begin
    if (bus.iDEBOUNCE_CLKS == DB_ZERO) begin
      win_s = {1'b0, DB_ONE};
    end else begin
      win_s = {1'b0, bus.iDEBOUNCE_CLKS};
    end
    for (int ch = 0; ch < pNUMCH; ch++) begin
      if (sync2_q[ch] != los_db_q[ch]) begin
        db_state_s[ch] = ST_PENDING;
      end else begin
        db_state_s[ch] = ST_STABLE;
      end
    end
  end

  // Next-state: count differing samples, flip the level on the Wth against the live window.
  always_comb begin
    los_db_d = los_db_q;
    toggle_s = CH_ZERO;
    for (int ch = 0; ch < pNUMCH; ch++) begin
      db_cnt_d[ch] = db_cnt_q[ch];
      case (db_state_s[ch])
        ST_STABLE: begin
          db_cnt_d[ch] = DB_ZERO;
        end
        ST_PENDING: begin
          if (({1'b0, db_cnt_q[ch]} + {1'b0, DB_ONE}) >= win_s) begin
            toggle_s[ch] = 1'b1;
            los_db_d[ch] = ~los_db_q[ch];
            db_cnt_d[ch] = DB_ZERO;
          end else if (db_cnt_q[ch] == DB_MAX) begin
            db_cnt_d[ch] = DB_MAX;
          end else begin
            db_cnt_d[ch] = db_cnt_q[ch] + DB_ONE;
          end
        end
        default: begin
          db_cnt_d[ch] = DB_ZERO;
        end
      endcase
    end
  end

  // Outputs: sticky set beats clear, a clear coinciding with a new loss leaves a count of one.
  always_comb begin
    rise_s   = toggle_s & ~los_db_q;
    sticky_d = sticky_q;
    for (int ch = 0; ch < pNUMCH; ch++) begin
      if (toggle_s[ch]) begin
        sticky_d[ch] = 1'b1;
      end else if (bus.iSTICKY_CLR[ch]) begin
        sticky_d[ch] = 1'b0;
      end else begin
        sticky_d[ch] = sticky_q[ch];
      end

      if (bus.iCNT_CLR) begin
        cnt_d[ch] = rise_s[ch] ? CNT_ONE : CNT_ZERO;
      end else if (rise_s[ch] && (cnt_q[ch] != CNT_MAX)) begin
        cnt_d[ch] = cnt_q[ch] + CNT_ONE;
      end else begin
        cnt_d[ch] = cnt_q[ch];
      end
    end

    if (int'(bus.iCNT_SEL) < pNUMCH) begin
      cnt_rd_d = cnt_q[bus.iCNT_SEL];
    end else begin
      cnt_rd_d = CNT_ZERO;
    end

    int_d = |(sticky_q & ~bus.iINT_MASK);
  end

  // Sticky flags, event counters and the registered read-back / interrupt.
  always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
    if (!iRST_100M_n) begin
      sticky_q <= CH_ZERO;
      cnt_rd_q <= CNT_ZERO;
      int_q    <= 1'b0;
      for (int ch = 0; ch < pNUMCH; ch++) begin
        cnt_q[ch] <= CNT_ZERO;
      end
    end else begin
      sticky_q <= sticky_d;
      cnt_rd_q <= cnt_rd_d;
      int_q    <= int_d;
      for (int ch = 0; ch < pNUMCH; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign bus.oLOS_DB         = los_db_q;
  assign bus.oLOS_CHG_STICKY = sticky_q;
  assign bus.oCNT_RD         = cnt_rd_q;
  assign bus.oINT            = int_q;

endmodule

// File: tb/tb_sfp_los_debounce.sv
// Bench for sfp_los_debounce: directed scenarios plus random traffic against a cycle-level reference model.
// A second instance with 4-bit event counters shares the same stimulus.
module tb_sfp_los_debounce;

  localparam int NCH = 24;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] los   = 24'hFFFFFF;
  logic [19:0] wclks = 20'd100;
  logic [23:0] mask  = 24'h0;
  logic [23:0] sclr  = 24'h0;
  logic        cclr  = 1'b0;
  logic [4:0]  sel   = 5'd0;

  int tests = 0;
  int fails = 0;

  sfp_los_debounce_if #(.pNUMCH(24), .pDBW(20), .pCNTW(16)) bus0 ();
  sfp_los_debounce_if #(.pNUMCH(24), .pDBW(20), .pCNTW(4))  bus4 ();

  assign bus0.iSFP_LOS_QUAL  = los;
  assign bus0.iDEBOUNCE_CLKS = wclks;
  assign bus0.iINT_MASK      = mask;
  assign bus0.iSTICKY_CLR    = sclr;
  assign bus0.iCNT_CLR       = cclr;
  assign bus0.iCNT_SEL       = sel;
  assign bus4.iSFP_LOS_QUAL  = los;
  assign bus4.iDEBOUNCE_CLKS = wclks;
  assign bus4.iINT_MASK      = mask;
  assign bus4.iSTICKY_CLR    = sclr;
  assign bus4.iCNT_CLR       = cclr;
  assign bus4.iCNT_SEL       = sel;

  sfp_los_debounce #(.pNUMCH(24), .pDBW(20), .pCNTW(16)) dut0 (
    .iCLK_100M   (clk),
    .iRST_100M_n (rst_n),
    .bus         (bus0)
  );

  sfp_los_debounce #(.pNUMCH(24), .pDBW(20), .pCNTW(4)) dut4 (
    .iCLK_100M   (clk),
    .iRST_100M_n (rst_n),
    .bus         (bus4)
  );

  always #5 clk = ~clk;

  // Reference model: delayed samples, run length of differing samples, event tallies.
  logic [23:0] m_s1, m_s2, m_db, m_sticky;
  int          m_run  [NCH];
  int          m_cnt  [NCH];
  int          m_cnt4 [NCH];
  int          m_rd, m_rd4;
  logic        m_int;

  task automatic model_reset();
    m_s1 = 24'hFFFFFF; m_s2 = 24'hFFFFFF; m_db = 24'hFFFFFF; m_sticky = 24'h0;
    m_rd = 0; m_rd4 = 0; m_int = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_run[c] = 0; m_cnt[c] = 0; m_cnt4[c] = 0;
    end
  endtask

  task automatic model_step();
    int   w, nrd, nrd4;
    logic nint, tog, rise;
    w = (wclks == 20'd0) ? 1 : int'(wclks);
    nrd = 0; nrd4 = 0;
    if (sel < 5'd24) begin
      nrd  = m_cnt[sel];
      nrd4 = m_cnt4[sel];
    end
    nint = |(m_sticky & ~mask);
    for (int c = 0; c < NCH; c++) begin
      tog = 1'b0;
      if (m_s2[c] != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] >= w) begin
          tog = 1'b1;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      rise = tog && !m_db[c];
      if (tog) begin
        m_db[c] = ~m_db[c];
        m_sticky[c] = 1'b1;
      end else if (sclr[c]) begin
        m_sticky[c] = 1'b0;
      end
      if (cclr) begin
        m_cnt[c]  = rise ? 1 : 0;
        m_cnt4[c] = rise ? 1 : 0;
      end else if (rise) begin
        if (m_cnt[c] < 65535) m_cnt[c]++;
        if (m_cnt4[c] < 15)   m_cnt4[c]++;
      end
    end
    m_rd = nrd; m_rd4 = nrd4; m_int = nint;
    m_s2 = m_s1; m_s1 = los;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    los = 24'hFFFFFF;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (bus0.oLOS_DB !== 24'hFFFFFF || bus0.oLOS_CHG_STICKY !== 24'h0 || bus0.oINT !== 1'b0 || bus0.oCNT_RD !== 16'd0) begin
      fails++;
      $display("FAIL reset_state db=%h sticky=%h int=%b rd=%0d, want ffffff/000000/0/0",
               bus0.oLOS_DB, bus0.oLOS_CHG_STICKY, bus0.oINT, bus0.oCNT_RD);
    end
    model_reset();
    #1 rst_n = 1'b1;
    repeat (5) tick();
    tests++;
    if (bus0.oLOS_DB !== 24'hFFFFFF || bus0.oLOS_CHG_STICKY !== 24'h0 || bus0.oINT !== 1'b0) begin
      fails++;
      $display("FAIL post_reset db=%h sticky=%h int=%b, want ffffff/000000/0",
               bus0.oLOS_DB, bus0.oLOS_CHG_STICKY, bus0.oINT);
    end
    for (int s = 0; s <= 24; s++) begin
      sel = 5'(s);
      tick();
      tests++;
      if (bus0.oCNT_RD !== 16'd0) begin
        fails++;
        $display("FAIL reset_cnt sel=%0d got %0d want 0", s, bus0.oCNT_RD);
      end
    end
  endtask

  task automatic test_window();
    bit early;
    early = 1'b0;
    wclks = 20'd100;
    tick();
    los[3] = 1'b0;
    for (int k = 1; k <= 103; k++) begin
      tick();
      if (k < 102 && bus0.oLOS_DB[3] !== 1'b1) early = 1'b1;
      if (k == 102) begin
        tests++;
        if (bus0.oLOS_DB[3] !== 1'b0 || bus0.oLOS_CHG_STICKY[3] !== 1'b1 || bus0.oINT !== 1'b0) begin
          fails++;
          $display("FAIL window_edge102 db3=%b sticky3=%b int=%b want 0/1/0",
                   bus0.oLOS_DB[3], bus0.oLOS_CHG_STICKY[3], bus0.oINT);
        end
      end
      if (k == 103) begin
        tests++;
        if (bus0.oINT !== 1'b1) begin
          fails++;
          $display("FAIL window_int got %b want 1", bus0.oINT);
        end
      end
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL window_early db3 went low before edge 102 (got 1 want 0 for early flag)");
    end
    sel = 5'd3;
    tick();
    tests++;
    if (bus0.oCNT_RD !== 16'd0) begin
      fails++;
      $display("FAIL window_cnt3 got %0d want 0", bus0.oCNT_RD);
    end
  endtask

  task automatic test_glitch();
    bit moved;
    moved = 1'b0;
    wclks = 20'd100;
    los[5] = 1'b0;
    repeat (99) tick();
    los[5] = 1'b1;
    for (int k = 0; k < 110; k++) begin
      tick();
      if (bus0.oLOS_DB[5] !== 1'b1 || bus0.oLOS_CHG_STICKY[5] !== 1'b0) moved = 1'b1;
    end
    tests++;
    if (moved) begin
      fails++;
      $display("FAIL glitch99 channel 5 changed (got moved=1 want 0)");
    end
    los[5] = 1'b0;
    for (int k = 1; k <= 210; k++) begin
      tick();
      if (k == 100) los[5] = 1'b1;
      if (k == 101 || k == 102) begin
        tests++;
        if (bus0.oLOS_DB[5] !== (k == 101 ? 1'b1 : 1'b0)) begin
          fails++;
          $display("FAIL glitch100 edge %0d db5=%b want %b", k, bus0.oLOS_DB[5], (k == 101));
        end
      end
    end
    tests++;
    if (bus0.oLOS_DB[5] !== 1'b1 || bus0.oLOS_CHG_STICKY[5] !== 1'b1) begin
      fails++;
      $display("FAIL glitch_return db5=%b sticky5=%b want 1/1", bus0.oLOS_DB[5], bus0.oLOS_CHG_STICKY[5]);
    end
  endtask

  task automatic test_counter();
    wclks = 20'd4;
    for (int r = 0; r < 5; r++) begin
      los[7] = 1'b0; repeat (8) tick();
      los[7] = 1'b1; repeat (8) tick();
    end
    sel = 5'd7;
    tick();
    tests++;
    if (bus0.oCNT_RD !== 16'd5) begin
      fails++;
      $display("FAIL cnt7_five got %0d want 5", bus0.oCNT_RD);
    end
    los[7] = 1'b0; repeat (8) tick();
    los[7] = 1'b1; repeat (5) tick();
    cclr = 1'b1;
    tick();
    cclr = 1'b0;
    tick();
    tests++;
    if (bus0.oCNT_RD !== 16'd1 || bus0.oLOS_DB[7] !== 1'b1) begin
      fails++;
      $display("FAIL cnt7_clr_rise got %0d db7=%b want 1/1", bus0.oCNT_RD, bus0.oLOS_DB[7]);
    end
    sel = 5'd5;
    tick();
    tests++;
    if (bus0.oCNT_RD !== 16'd0) begin
      fails++;
      $display("FAIL cnt5_cleared got %0d want 0", bus0.oCNT_RD);
    end
  endtask

  task automatic test_saturate();
    wclks = 20'd0;
    los[1] = 1'b0; tick();
    los[1] = 1'b1; tick();
    tick();
    tests++;
    if (bus0.oLOS_DB[1] !== 1'b0) begin
      fails++;
      $display("FAIL w0_toggle db1=%b want 0", bus0.oLOS_DB[1]);
    end
    tick();
    tests++;
    if (bus0.oLOS_DB[1] !== 1'b1) begin
      fails++;
      $display("FAIL w0_return db1=%b want 1", bus0.oLOS_DB[1]);
    end
    for (int e = 0; e < 20; e++) begin
      los[0] = 1'b0; repeat (4) tick();
      los[0] = 1'b1; repeat (4) tick();
    end
    sel = 5'd0;
    tick();
    tests++;
    if (bus4.oCNT_RD !== 4'd15 || bus0.oCNT_RD !== 16'd20) begin
      fails++;
      $display("FAIL cnt_saturate w4=%0d w16=%0d want 15/20", bus4.oCNT_RD, bus0.oCNT_RD);
    end
    sclr[0] = 1'b1; tick(); sclr[0] = 1'b0;
    tests++;
    if (bus0.oLOS_CHG_STICKY[0] !== 1'b0) begin
      fails++;
      $display("FAIL sticky_clear got %b want 0", bus0.oLOS_CHG_STICKY[0]);
    end
    los[0] = 1'b0; tick(); tick();
    sclr[0] = 1'b1; tick(); sclr[0] = 1'b0;
    tests++;
    if (bus0.oLOS_CHG_STICKY[0] !== 1'b1 || bus0.oLOS_DB[0] !== 1'b0) begin
      fails++;
      $display("FAIL sticky_set_wins sticky0=%b db0=%b want 1/0", bus0.oLOS_CHG_STICKY[0], bus0.oLOS_DB[0]);
    end
  endtask

  task automatic test_mask();
    sclr = ~24'h000008; tick(); sclr = 24'h0;
    tick();
    tests++;
    if (bus0.oLOS_CHG_STICKY !== 24'h000008 || bus0.oINT !== 1'b1) begin
      fails++;
      $display("FAIL mask_pre sticky=%h int=%b want 000008/1", bus0.oLOS_CHG_STICKY, bus0.oINT);
    end
    mask = 24'h000008; tick();
    tests++;
    if (bus0.oINT !== 1'b0) begin
      fails++;
      $display("FAIL mask_on int=%b want 0", bus0.oINT);
    end
    mask = 24'h0; tick();
    tests++;
    if (bus0.oINT !== 1'b1) begin
      fails++;
      $display("FAIL mask_off int=%b want 1", bus0.oINT);
    end
  endtask

  task automatic test_async_reset();
    bit moved;
    moved = 1'b0;
    wclks = 20'd100;
    los[3] = 1'b1;
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus0.oLOS_DB !== 24'hFFFFFF || bus0.oLOS_CHG_STICKY !== 24'h0 || bus0.oINT !== 1'b0 ||
        bus0.oCNT_RD !== 16'd0 || bus4.oCNT_RD !== 4'd0) begin
      fails++;
      $display("FAIL async_reset db=%h sticky=%h int=%b rd=%0d rd4=%0d want ffffff/000000/0/0/0",
               bus0.oLOS_DB, bus0.oLOS_CHG_STICKY, bus0.oINT, bus0.oCNT_RD, bus4.oCNT_RD);
    end
    model_reset();
    los = 24'hFFFFFF;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (bus0.oLOS_DB !== 24'hFFFFFF || bus0.oLOS_CHG_STICKY !== 24'h0) moved = 1'b1;
    end
    tests++;
    if (moved) begin
      fails++;
      $display("FAIL async_reset_discard state changed after reset (got moved=1 want 0)");
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) wclks = 20'($urandom_range(0, 6));
      if (cyc % 100 == 0) mask = 24'($urandom);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 5) == 0) los[c] = ~los[c];
      end
      sclr = ($urandom_range(0, 3) == 0) ? 24'($urandom & $urandom & $urandom) : 24'h0;
      cclr = ($urandom_range(0, 63) == 0);
      sel  = 5'($urandom_range(0, 31));
      tick();
      tests++;
      if (bus0.oLOS_DB !== m_db) begin
        fails++;
        $display("FAIL rnd_db cyc=%0d got %h want %h", cyc, bus0.oLOS_DB, m_db);
      end
      tests++;
      if (bus0.oLOS_CHG_STICKY !== m_sticky) begin
        fails++;
        $display("FAIL rnd_sticky cyc=%0d got %h want %h", cyc, bus0.oLOS_CHG_STICKY, m_sticky);
      end
      tests++;
      if (bus0.oINT !== m_int) begin
        fails++;
        $display("FAIL rnd_int cyc=%0d got %b want %b", cyc, bus0.oINT, m_int);
      end
      tests++;
      if (bus0.oCNT_RD !== 16'(m_rd)) begin
        fails++;
        $display("FAIL rnd_cnt cyc=%0d got %0d want %0d", cyc, bus0.oCNT_RD, m_rd);
      end
      tests++;
      if (bus4.oCNT_RD !== 4'(m_rd4)) begin
        fails++;
        $display("FAIL rnd_cnt4 cyc=%0d got %0d want %0d", cyc, bus4.oCNT_RD, m_rd4);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_window();
    test_glitch();
    test_counter();
    test_saturate();
    test_mask();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
